// File: rtl/snake_pkg.sv
// Shared direction/stage encodings and helpers for the snake direction front end.
package snake_pkg;

    // Move codes as consumed by the regfile move input.
    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_RIGHT = 3'd2,
        DIR_DOWN  = 3'd3,
        DIR_LEFT  = 3'd4
    } dir_t;

    // Game stage as published by the processor.
    typedef enum logic [31:0] {
        STAGE_IDLE = 32'd0,
        STAGE_MENU = 32'd1,
        STAGE_PLAY = 32'd2
    } stage_t;

    // Direction that would reverse the snake onto itself.
    function automatic dir_t opposite(input dir_t d);
        case (d)
            DIR_UP:    opposite = DIR_DOWN;
            DIR_DOWN:  opposite = DIR_UP;
            DIR_RIGHT: opposite = DIR_LEFT;
            DIR_LEFT:  opposite = DIR_RIGHT;
            default:   opposite = DIR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-FF synchroniser, stability counter, debounced level and press pulse.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 18
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_ni,
    output logic pressed_o,
    output logic rise_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             rise_q;
    logic             level;

    assign level = ~sync_q[1];

    // Count consecutive cycles the synced level disagrees with the accepted level.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (level != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = level;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Synchroniser, debounce state and rise pulse registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q   <= '1;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], btn_ni};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= stable_d & ~stable_q;
        end
    end

    assign pressed_o = stable_q;
    assign rise_o    = rise_q;

endmodule

// File: rtl/snake_dir_ctrl.sv
// Per-player direction front end: debounced buttons -> direction requests ->
// move code committed on the game-step tick (no reversal within one step).
// Define DIR_QUEUE_EN to buffer up to two requests instead of one.
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 18,
    parameter int unsigned RESET_DIR       = 2
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        up_n,
    input  logic        right_n,
    input  logic        down_n,
    input  logic        left_n,
    input  logic [31:0] stage,
    input  logic        step_tick,
    output logic [31:0] move,
    output logic        key_event,
    output logic [3:0]  btn_state
);

    localparam dir_t RESET_MOVE = dir_t'(RESET_DIR[2:0]);

    logic [3:0] raw_n;
    logic [3:0] rise;
    logic       req_vld;
    dir_t       req_dir;
    dir_t       move_q, move_d;

    assign raw_n = {left_n, down_n, right_n, up_n};

    for (genvar g = 0; g < 4; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_btn (
            .clk_i     (clock),
            .rst_ni    (resetn),
            .btn_ni    (raw_n[g]),
            .pressed_o (btn_state[g]),
            .rise_o    (rise[g])
        );
    end

    assign key_event = |rise;

    // Pick one request when several presses land in the same cycle.
    always_comb begin
        req_vld = |rise;
        req_dir = DIR_NONE;
        if (rise[0])      req_dir = DIR_UP;
        else if (rise[1]) req_dir = DIR_RIGHT;
        else if (rise[2]) req_dir = DIR_DOWN;
        else if (rise[3]) req_dir = DIR_LEFT;
    end

`ifdef DIR_QUEUE_EN
    dir_t       fifo0_q, fifo0_d;
    dir_t       fifo1_q, fifo1_d;
    logic [1:0] fcnt_q, fcnt_d;

    // Pop-then-push so a tick and a press in the same cycle are both honoured.
    always_comb begin
        move_d  = move_q;
        fifo0_d = fifo0_q;
        fifo1_d = fifo1_q;
        fcnt_d  = fcnt_q;
        case (stage)
            STAGE_MENU: begin
                if (req_vld) move_d = req_dir;
                fcnt_d = '0;
            end
            STAGE_PLAY: begin
                if (step_tick && (fcnt_q != 2'd0)) begin
                    if (fifo0_q != opposite(move_q)) move_d = fifo0_q;
                    fifo0_d = fifo1_q;
                    fcnt_d  = fcnt_q - 2'd1;
                end
                if (req_vld) begin
                    case (fcnt_d)
                        2'd0: begin
                            fifo0_d = req_dir;
                            fcnt_d  = 2'd1;
                        end
                        2'd1: begin
                            fifo1_d = req_dir;
                            fcnt_d  = 2'd2;
                        end
                        default: fifo1_d = req_dir;
                    endcase
                end
            end
            default: fcnt_d = '0;
        endcase
    end

    // Committed move and request FIFO.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            move_q  <= RESET_MOVE;
            fifo0_q <= DIR_NONE;
            fifo1_q <= DIR_NONE;
            fcnt_q  <= '0;
        end else begin
            move_q  <= move_d;
            fifo0_q <= fifo0_d;
            fifo1_q <= fifo1_d;
            fcnt_q  <= fcnt_d;
        end
    end
`else
    dir_t pend_q, pend_d;
    logic pend_vld_q, pend_vld_d;

    // Commit the old pending on the tick; a same-cycle press becomes the new pending.
    always_comb begin
        move_d     = move_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        case (stage)
            STAGE_MENU: begin
                if (req_vld) move_d = req_dir;
                pend_vld_d = 1'b0;
            end
            STAGE_PLAY: begin
                if (step_tick && pend_vld_q) begin
                    if (pend_q != opposite(move_q)) move_d = pend_q;
                    pend_vld_d = 1'b0;
                end
                if (req_vld) begin
                    pend_d     = req_dir;
                    pend_vld_d = 1'b1;
                end
            end
            default: pend_vld_d = 1'b0;
        endcase
    end

    // Committed move and single pending request.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            move_q     <= RESET_MOVE;
            pend_q     <= DIR_NONE;
            pend_vld_q <= 1'b0;
        end else begin
            move_q     <= move_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
        end
    end
`endif

    assign move = {29'd0, move_q};

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Randomised bench for snake_dir_ctrl against a behavioural reference model.
`timescale 1ns/1ps
module tb_snake_dir_ctrl;

    localparam int D = 4;
`ifdef DIR_QUEUE_EN
    localparam int QCAP = 2;
`else
    localparam int QCAP = 1;
`endif
    localparam int NCYC = 4000;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        up_n = 1'b1, right_n = 1'b1, down_n = 1'b1, left_n = 1'b1;
    logic [31:0] stage = 32'd2;
    logic        step_tick = 1'b0;
    logic [31:0] move;
    logic        key_event;
    logic [3:0]  btn_state;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit hist [4][$];   // pressed samples seen at each edge, oldest first
    bit stable_m [4];
    bit ev_m [4];
    int move_m;
    int pend [$];

    // Stimulus state (index 0 up, 1 right, 2 down, 3 left; 1 = released)
    bit raw [4];
    int hold [4];

    snake_dir_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3),
        .RESET_DIR       (2)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .up_n      (up_n),
        .right_n   (right_n),
        .down_n    (down_n),
        .left_n    (left_n),
        .stage     (stage),
        .step_tick (step_tick),
        .move      (move),
        .key_event (key_event),
        .btn_state (btn_state)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 4; b++) begin
            hist[b].delete();
            repeat (D + 2) hist[b].push_back(1'b0);
            stable_m[b] = 1'b0;
            ev_m[b]     = 1'b0;
        end
        move_m = 2;
        pend.delete();
    endtask

    // One clock edge of the reference behaviour.
    task automatic model_step();
        int  req;
        int  d;
        bit  all_diff;
        if (!resetn) begin
            model_reset();
            return;
        end
        req = 0;
        for (int b = 3; b >= 0; b--) if (ev_m[b]) req = b + 1;
        if (stage == 32'd1) begin
            if (req != 0) move_m = req;
            pend.delete();
        end else if (stage == 32'd2) begin
            if (step_tick && pend.size() > 0) begin
                d = pend.pop_front();
                if (!((d - move_m == 2) || (move_m - d == 2))) move_m = d;
            end
            if (req != 0) begin
                if (pend.size() < QCAP) pend.push_back(req);
                else pend[pend.size() - 1] = req;
            end
        end else begin
            pend.delete();
        end
        // A level is accepted once D consecutive synchronised samples disagree with it.
        for (int b = 0; b < 4; b++) begin
            hist[b].push_back(!raw[b]);
            void'(hist[b].pop_front());
            all_diff = 1'b1;
            for (int i = 0; i < D; i++) if (hist[b][i] == stable_m[b]) all_diff = 1'b0;
            ev_m[b] = 1'b0;
            if (all_diff) begin
                stable_m[b] = !stable_m[b];
                ev_m[b]     = stable_m[b];
            end
        end
    endtask

    task automatic check_outputs(input string phase);
        check_eq({phase, ".move"}, move, move_m);
        check_eq({phase, ".key_event"}, {31'd0, key_event},
                 {31'd0, (ev_m[0] | ev_m[1] | ev_m[2] | ev_m[3])});
        check_eq({phase, ".btn_state"}, {28'd0, btn_state},
                 {28'd0, stable_m[3], stable_m[2], stable_m[1], stable_m[0]});
    endtask

    task automatic drive_inputs(input int cyc);
        int pick;
        for (int b = 0; b < 4; b++) begin
            if (hold[b] == 0) begin
                raw[b]  = ($urandom_range(0, 9) < 3) ? 1'b0 : 1'b1;
                hold[b] = $urandom_range(1, 12);
            end
            hold[b]--;
        end
        {left_n, down_n, right_n, up_n} = {raw[3], raw[2], raw[1], raw[0]};
        step_tick = ($urandom_range(0, 4) == 0);
        if (cyc % 64 == 0) begin
            pick = $urandom_range(0, 7);
            case (pick)
                0:       stage = 32'd0;
                1, 2:    stage = 32'd1;
                3:       stage = 32'd3 + 32'($urandom_range(0, 20));
                default: stage = 32'd2;
            endcase
        end
    endtask

    initial begin
        for (int b = 0; b < 4; b++) begin
            raw[b]  = 1'b1;
            hold[b] = 0;
        end
        model_reset();
        @(negedge clock);
        @(negedge clock);
        check_outputs("reset");
        resetn = 1'b1;
        for (int cyc = 1; cyc <= NCYC; cyc++) begin
            @(posedge clock);
            model_step();
            @(negedge clock);
            check_outputs("run");
            drive_inputs(cyc);
            if (cyc % 900 == 450) begin
                // Asynchronous reset pulse in the middle of the low phase.
                #2 resetn = 1'b0;
                #1;
                model_reset();
                check_outputs("async_rst");
                #1 resetn = 1'b1;
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/snake_dir_ctrl.md
Name: snake_dir_ctrl

Overview:
Per-player direction front end for the snake game. Conditions the raw active-low direction buttons with synchronisation and debounce, and turns presses into direction requests. Requests are committed on the game-step tick, so the snake cannot reverse into itself within one step. The 32-bit move code drives the regfile move input (move1/move2); one instance per player.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable cycles before a button level is accepted (5 ms at 50 MHz)
CNT_W, 18, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES
RESET_DIR, 2, move code loaded at reset (2 = right)

Ports:
clock  in  1  system clock (CLOCK_50 domain)
resetn  in  1  asynchronous active-low reset
up_n  in  1  raw button, 0 = pressed, asynchronous
right_n  in  1  raw button, 0 = pressed, asynchronous
down_n  in  1  raw button, 0 = pressed, asynchronous
left_n  in  1  raw button, 0 = pressed, asynchronous
stage  in  32  game stage from processor snake_data (0 idle, 1 menu, 2 play)
step_tick  in  1  one-cycle pulse, game advances one step
move  out  32  committed direction: 1 up, 2 right, 3 down, 4 left
key_event  out  1  one-cycle pulse on any accepted press
btn_state  out  4  debounced pressed levels {left,down,right,up}, 1 = pressed

Behaviour:
- Reset (resetn=0, async): move=RESET_DIR, key_event=0, btn_state=0, synchronisers=1 (released), counters=0, pending empty.
- Sync: 2-FF synchroniser per button. The inverted output is the pressed level.
- Debounce, per button:
  - counter increments while synced level != stable level; resets to 0 when they are equal.
  - When counter reaches DEBOUNCE_CYCLES-1, stable takes the synced level and the counter clears.
  - Latency from a clean edge to btn_state change: DEBOUNCE_CYCLES+2 cycles.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes btn_state.
- Press event: btn_state bit rises 0->1. key_event pulses in the same cycle as the rise. Holding a button produces no further events.
- Simultaneous presses in one cycle: priority up > right > down > left. Exactly one request is generated.
- stage=0: events ignored, pending cleared, move held.
- stage=1 (menu): a press writes move directly on the next edge; no reverse rule; pending unused.
- stage=2 (play):
  - A press loads pending; a newer press overwrites an uncommitted pending.
  - On step_tick with pending valid: if pending is the opposite of move (1<->3, 2<->4), discard it; otherwise move=pending. Pending is cleared in both cases.
  - step_tick with pending empty: move unchanged.
  - step_tick and a press in the same cycle: the old pending is committed and the new press becomes pending for the next tick.
  - A request equal to move is committed as a no-op.
- Any other stage value: behaves as stage=0.
- Leaving stage 2 clears pending; move keeps its value across all stage transitions.
- move only ever holds 1..4; bits [31:3] always 0.

Optional Feature:
DIR_QUEUE_EN:
- Defined: pending becomes a 2-entry FIFO.
  - A press pushes; a press while full overwrites the tail entry.
  - step_tick pops one entry and applies the reverse check against the current move.
  - A discarded entry still consumes that tick.
  - Push and pop in the same cycle are both honoured.
- Undefined: single-entry overwrite pending exactly as described above.

Decomposition:
- Package snake_pkg holds:
  - DIR_UP=1, DIR_RIGHT=2, DIR_DOWN=3, DIR_LEFT=4
  - STAGE_IDLE=0, STAGE_MENU=1, STAGE_PLAY=2
  - function opposite(dir)
- Sub-module btn_debounce (synchroniser + counter + stable register + rise pulse), instantiated 4 times.
- Top holds the priority encoder, pending/FIFO, and the commit logic.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4.
1. Reset, stage=2, no input -> move=2, btn_state=0, key_event=0.
2. up_n low for 3 cycles then high, stage=2 -> no key_event, btn_state stays 0; up_n low 10 cycles -> key_event pulse 6 cycles after the edge, btn_state[0]=1.
3. stage=2, move=2, press left, then step_tick -> move stays 2 (reversal discarded); press up, step_tick -> move=1.
4. stage=2, move=2, press up then down before a tick, tick -> move=3 (newest wins, non-reverse). With DIR_QUEUE_EN: move=1 after tick 1, move=1 after tick 2 (down discarded as opposite of up).
5. stage=1, move=2, press left -> move=4 on the next edge with no tick; up and right pressed in the same cycle -> move=1.
6. stage=2 with pending=1, assert resetn=0 mid-cycle -> move=2 immediately and pending empty; after release, step_tick -> move=2.
